// File: rtl/everloop_ctrl.sv
// everloop_ctrl: frame sequencer for the everloop LED ring.
// On start, reads N_BYTES bytes of the everloop RAM in address order and shifts
// each byte out MSB first as WS2812-style bit slots on led_dout. Each frame ends
// with a low latch gap, and done pulses in the last cycle of that gap.
//
// Ports:
//   clk          system clock, posedge
//   rst          asynchronous active-high reset
//   start        1-cycle frame request, ignored while busy or during done
//   ram_addr_rd  RAM read address
//   ram_rd       RAM read enable, 1-cycle pulse
//   ram_d        RAM read data, valid on the posedge after the ram_rd cycle
//   led_dout     serial LED data line
//   busy         high from the cycle after an accepted start until done
//   done         1-cycle pulse at the end of the latch gap
//
// Build option EVERLOOP_AUTO_REFRESH_EN: when defined, frames repeat back to
// back after a single start. Byte 0 is then fetched during the latch gap, so
// consecutive frames start exactly one frame length apart.
//
// All outputs are registered. led_dout and ram_rd follow the state by one
// cycle, which gives the 3-cycle start-to-first-rise latency.
module everloop_ctrl #(
    parameter int unsigned N_BYTES   = 140,
    parameter int unsigned BIT_CYC   = 63,
    parameter int unsigned T0H_CYC   = 18,
    parameter int unsigned T1H_CYC   = 35,
    parameter int unsigned LATCH_CYC = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] ram_addr_rd,
    output logic       ram_rd,
    input  logic [7:0] ram_d,
    output logic       led_dout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, HIGH, LOW, LATCH} state_t;

    localparam logic [11:0] T0H_LAST   = 12'(T0H_CYC - 1);
    localparam logic [11:0] T1H_LAST   = 12'(T1H_CYC - 1);
    localparam logic [11:0] T0L_LAST   = 12'(BIT_CYC - T0H_CYC - 1);
    localparam logic [11:0] T1L_LAST   = 12'(BIT_CYC - T1H_CYC - 1);
    localparam logic [11:0] LATCH_LAST = 12'(LATCH_CYC - 1);
    localparam logic [7:0]  LAST_IDX   = 8'(N_BYTES - 1);

    state_t      state;
    logic [7:0]  idx;
    logic [2:0]  bit_idx;
    logic [11:0] cnt;
    logic [7:0]  shreg;
    logic [7:0]  hold;
    logic        cur_one;
    logic [7:0]  next_byte;

    assign cur_one = shreg[bit_idx];

    // Prefetched data is captured on count 2. When the low phase is only
    // 3 cycles long, that capture cycle is also the last cycle of the phase,
    // so the fresh read data is taken directly instead of the old hold value.
    assign next_byte = (cnt == 12'd2) ? ram_d : hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            bit_idx     <= '0;
            cnt         <= '0;
            shreg       <= '0;
            hold        <= '0;
            ram_addr_rd <= '0;
            ram_rd      <= 1'b0;
            led_dout    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    led_dout <= 1'b0;
                    // A start in the done cycle is dropped.
                    if (start && !done) begin
                        state <= FETCH;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                FETCH: begin
                    ram_rd      <= 1'b1;
                    ram_addr_rd <= idx;
                    state       <= LOAD;
                end
                LOAD: begin
                    shreg   <= ram_d;
                    bit_idx <= 3'd7;
                    cnt     <= '0;
                    state   <= HIGH;
                end
                HIGH: begin
                    led_dout <= 1'b1;
                    if (cnt == (cur_one ? T1H_LAST : T0H_LAST)) begin
                        cnt   <= '0;
                        state <= LOW;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                LOW: begin
                    led_dout <= 1'b0;
                    // During bit 0, prefetch the next byte so byte boundaries stay gap-free.
                    if (bit_idx == 3'd0 && idx != LAST_IDX) begin
                        if (cnt == 12'd0) begin
                            ram_rd      <= 1'b1;
                            ram_addr_rd <= idx + 8'd1;
                        end
                        if (cnt == 12'd2)
                            hold <= ram_d;
                    end
                    if (cnt == (cur_one ? T1L_LAST : T0L_LAST)) begin
                        cnt <= '0;
                        if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            state   <= HIGH;
                        end else if (idx != LAST_IDX) begin
                            shreg   <= next_byte;
                            idx     <= idx + 8'd1;
                            bit_idx <= 3'd7;
                            state   <= HIGH;
                        end else begin
                            state <= LATCH;
                        end
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                LATCH: begin
                    led_dout <= 1'b0;
`ifdef EVERLOOP_AUTO_REFRESH_EN
                    // Fetch byte 0 of the next frame inside the gap.
                    if (cnt == 12'd0) begin
                        ram_rd      <= 1'b1;
                        ram_addr_rd <= '0;
                    end
                    if (cnt == 12'd2)
                        hold <= ram_d;
`endif
                    if (cnt == LATCH_LAST) begin
                        cnt  <= '0;
                        done <= 1'b1;
`ifdef EVERLOOP_AUTO_REFRESH_EN
                        shreg   <= next_byte;
                        idx     <= '0;
                        bit_idx <= 3'd7;
                        state   <= HIGH;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_everloop_ctrl.sv
// tb_everloop_ctrl: randomized self-checking bench for everloop_ctrl.
// It uses a small frame geometry so that many frames fit in a short run.
// The expected waveform is derived from the RAM contents: one slot per bit,
// MSB first, with the high time chosen by the bit value, followed by the latch
// gap and a single done pulse.
module tb_everloop_ctrl;

    localparam int unsigned NB = 8;
    localparam int unsigned BC = 12;
    localparam int unsigned T0 = 3;
    localparam int unsigned T1 = 7;
    localparam int unsigned LC = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] ram_addr_rd;
    logic       ram_rd;
    logic [7:0] ram_d = 8'h00;
    logic       led_dout;
    logic       busy;
    logic       done;

    logic [7:0] ram [256];
    int unsigned addr_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n = 0;
    bit          inject_mid = 1'b0;

    always #5 clk = ~clk;

    everloop_ctrl #(
        .N_BYTES  (NB),
        .BIT_CYC  (BC),
        .T0H_CYC  (T0),
        .T1H_CYC  (T1),
        .LATCH_CYC(LC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ram_addr_rd(ram_addr_rd),
        .ram_rd     (ram_rd),
        .ram_d      (ram_d),
        .led_dout   (led_dout),
        .busy       (busy),
        .done       (done)
    );

    // RAM model: registers read data on negedge and records every read address.
    always @(negedge clk) begin
        if (ram_rd) begin
            ram_d <= ram[ram_addr_rd];
            addr_q.push_back(32'(ram_addr_rd));
        end
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advances one cycle. Optionally fires a start pulse 50 cycles into the
    // frame; the DUT must ignore it because busy is high at that point.
    task automatic step();
        @(negedge clk);
        n++;
        start = (inject_mid && n == 50);
    endtask

    task automatic fill_ram(input int unsigned mode);
        for (int unsigned b = 0; b < 256; b++)
            ram[b] = (mode == 0) ? 8'h00 : 8'($urandom);
        if (mode == 2)
            ram[0] = 8'hA5;
    endtask

    task automatic run_frame(input bit mid, input bit at_done);
        int unsigned exp_h[$];
        int unsigned c, h, l;
        for (int unsigned b = 0; b < NB; b++)
            for (int i = 7; i >= 0; i--)
                exp_h.push_back(ram[b][i] ? T1 : T0);
        addr_q.delete();
        n = 0;
        inject_mid = mid;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("led_low_fetch", led_dout, 0);
        c = 0;
        while (!led_dout && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("start_latency", c, 3);
        for (int unsigned s = 0; s < NB * 8; s++) begin
            h = 0;
            while (led_dout && h < 1000) begin
                h++;
                step();
            end
            l = 0;
            while (!led_dout && !done && l < 5000) begin
                l++;
                step();
            end
            check($sformatf("high_b%0d_s%0d", s / 8, s % 8), h, exp_h[s]);
            if (s < NB * 8 - 1)
                check($sformatf("slot_b%0d_s%0d", s / 8, s % 8), h + l, BC);
            else
                check("last_low_plus_latch", l, BC - h + LC - 1);
        end
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 1);
        check("led_at_done", led_dout, 0);
        inject_mid = 1'b0;
        start = at_done;
        @(negedge clk);
        start = 1'b0;
        check("done_single", done, 0);
        check("busy_fall", busy, 0);
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_led", led_dout, 0);
        check("rd_count", unsigned'(addr_q.size()), NB);
        for (int unsigned i = 0; i < NB && i < addr_q.size(); i++)
            check($sformatf("rd_addr_%0d", i), addr_q[i], i);
    endtask

    initial begin
        int unsigned c;
        rst = 1'b1;
        start = 1'b0;
        fill_ram(0);
        repeat (3) @(negedge clk);
        check("rst_led", led_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", ram_rd, 0);
        check("rst_addr", ram_addr_rd, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fill_ram(0);
        run_frame(1'b0, 1'b0);
        fill_ram(2);
        run_frame(1'b0, 1'b0);
        fill_ram(1);
        run_frame(1'b1, 1'b0);
        fill_ram(1);
        run_frame(1'b0, 1'b1);

        // Reset in the middle of a frame while the line is high.
        fill_ram(1);
        addr_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (NB * 4 * BC) @(negedge clk);
        c = 0;
        while (!led_dout && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("led_high_before_rst", led_dout, 1);
        rst = 1'b1;
        #1;
        check("async_rst_led", led_dout, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_addr", ram_addr_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_ram(1);
        run_frame(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
